// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: aluop encodings, exception codes, bus widths.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package mem_stage_pkg;

  localparam int ALUOP_BUS    = 8;
  localparam int EXC_CODE_BUS = 5;
  localparam int STALL_BUS    = 4;

  localparam logic [31:0] PC_INIT = 32'hBFC0_0000;

  // stall vector bit values
  localparam logic NOSTOP = 1'b0;
  localparam logic STOP   = 1'b1;

  typedef logic [ALUOP_BUS-1:0]    aluop_t;
  typedef logic [EXC_CODE_BUS-1:0] exc_t;

  localparam aluop_t ALUOP_NOP = 8'h00;
  localparam aluop_t ALUOP_ADD = 8'h18;
  localparam aluop_t ALUOP_LB  = 8'h90;
  localparam aluop_t ALUOP_LBU = 8'h91;
  localparam aluop_t ALUOP_LH  = 8'h92;
  localparam aluop_t ALUOP_LHU = 8'h93;
  localparam aluop_t ALUOP_LW  = 8'h94;
  localparam aluop_t ALUOP_SB  = 8'h98;
  localparam aluop_t ALUOP_SH  = 8'h99;
  localparam aluop_t ALUOP_SW  = 8'h9A;

  localparam exc_t EXC_NONE = 5'h10;
  localparam exc_t EXC_ADEL = 5'h04;
  localparam exc_t EXC_ADES = 5'h05;
  localparam exc_t EXC_DBE  = 5'h07;
  localparam exc_t EXC_SYS  = 5'h08;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} mem_state_t;

  // one data-bus transaction as seen on the dm_* pins
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dm_txn_t;

  function automatic logic is_load(input aluop_t op);
    return op inside {ALUOP_LB, ALUOP_LBU, ALUOP_LH, ALUOP_LHU, ALUOP_LW};
  endfunction

  function automatic logic is_store(input aluop_t op);
    return op inside {ALUOP_SB, ALUOP_SH, ALUOP_SW};
  endfunction

  function automatic logic is_half(input aluop_t op);
    return op inside {ALUOP_LH, ALUOP_LHU, ALUOP_SH};
  endfunction

  function automatic logic is_word(input aluop_t op);
    return op inside {ALUOP_LW, ALUOP_SW};
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane formatting: store lane enables/replication and load extraction/extension.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: aluop, addr_lo (byte offset), din (store data), load_buf (captured read word)
//        -> be, wdata (store lanes), load_data (extended load result).
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [ALUOP_BUS-1:0] aluop,
  input  logic [1:0]           addr_lo,
  input  logic [31:0]          din,
  input  logic [31:0]          load_buf,
  output logic [3:0]           be,
  output logic [31:0]          wdata,
  output logic [31:0]          load_data
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign shifted = load_buf >> {addr_lo, 3'b000};
  assign byte_v  = shifted[7:0];
  assign half_v  = addr_lo[1] ? load_buf[31:16] : load_buf[15:0];

  always_comb begin
    be        = 4'b1111;
    wdata     = din;
    load_data = load_buf;
    case (aluop)
      ALUOP_SB: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{din[7:0]}};
      end
      ALUOP_SH: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{din[15:0]}};
      end
      ALUOP_LB:  load_data = {{24{byte_v[7]}}, byte_v};
      ALUOP_LBU: load_data = {24'd0, byte_v};
      ALUOP_LH:  load_data = {{16{half_v[15]}}, half_v};
      ALUOP_LHU: load_data = {16'd0, half_v};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: launches loads/stores on the data bus and registers the MEM/WB results.
// Latency: 1 cycle for non-memory ops; memory ops stall until dm_ack, then result one cycle later.
// Backpressure: stallreq_mem holds upstream while a bus op is outstanding; dm_req held until dm_ack.
// Ports: cpu_clk_50M / cpu_rst_n (async, active-high); mem_* from EX/MEM; stall, flush;
//        dm_* data bus; wb_* registered to MEM/WB; stallreq_mem.
// Build option: DM_TIMEOUT_EN adds a 255-cycle bus timeout raising EXC_DBE.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    cpu_clk_50M,
  input  logic                    cpu_rst_n,
  input  logic [ALUOP_BUS-1:0]    mem_aluop,
  input  logic [4:0]              mem_wa,
  input  logic                    mem_wreg,
  input  logic                    mem_whilo,
  input  logic                    mem_mreg,
  input  logic [31:0]             mem_wd,
  input  logic [31:0]             mem_din,
  input  logic [63:0]             mem_hilo,
  input  logic [31:0]             mem_pc,
  input  logic                    mem_in_delay,
  input  logic [EXC_CODE_BUS-1:0] mem_exccode,
  input  logic [STALL_BUS-1:0]    stall,
  input  logic                    flush,
  output logic                    dm_req,
  output logic                    dm_we,
  output logic [3:0]              dm_be,
  output logic [31:0]             dm_addr,
  output logic [31:0]             dm_wdata,
  input  logic                    dm_ack,
  input  logic [31:0]             dm_rdata,
  output logic [4:0]              wb_wa,
  output logic                    wb_wreg,
  output logic                    wb_whilo,
  output logic [31:0]             wb_wd,
  output logic [63:0]             wb_hilo,
  output logic [31:0]             wb_pc,
  output logic                    wb_in_delay,
  output logic [EXC_CODE_BUS-1:0] wb_exccode,
  output logic                    stallreq_mem
);

  mem_state_t  state;
  logic        flush_seen;
  logic [31:0] load_buf;
  dm_txn_t     txn_q, txn_now, bus_txn;
  logic        op_load, op_store, misaligned, launchable, launch;
  logic        drop_txn, done_exit, timeout, bus_err;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, load_data;
  exc_t        exc_code;
  logic        unused_stall;

  assign unused_stall = ^stall[STALL_BUS-2:0];

  assign op_load    = is_load(mem_aluop);
  assign op_store   = is_store(mem_aluop);
  assign misaligned = (is_half(mem_aluop) && mem_wd[0]) ||
                      (is_word(mem_aluop) && (mem_wd[1:0] != 2'b00));
  assign launchable = (op_load || op_store) && (mem_exccode == EXC_NONE) && !misaligned;
  assign launch     = launchable && (state == ST_IDLE) && !flush;
  // a flushed transaction still has to finish on the bus, its result is thrown away
  assign drop_txn   = flush || flush_seen;
  assign done_exit  = flush || (stall[STALL_BUS-1] == NOSTOP);

  // reset gates these directly so the bus sees the drop without waiting for an edge
  assign stallreq_mem = !cpu_rst_n && launchable && (state != ST_DONE);
  assign dm_req       = !cpu_rst_n && (launch || (state == ST_WAIT));

  mem_align u_align (
    .aluop     (mem_aluop),
    .addr_lo   (mem_wd[1:0]),
    .din       (mem_din),
    .load_buf  (load_buf),
    .be        (al_be),
    .wdata     (al_wdata),
    .load_data (load_data)
  );

  assign txn_now  = '{we: op_store, be: al_be, addr: mem_wd, wdata: al_wdata};
  // while waiting, drive the captured copy: EX/MEM may change under a flush
  assign bus_txn  = (state == ST_WAIT) ? txn_q : txn_now;
  assign dm_we    = bus_txn.we;
  assign dm_be    = bus_txn.be;
  assign dm_addr  = bus_txn.addr;
  assign dm_wdata = bus_txn.wdata;

  always_comb begin
    exc_code = EXC_NONE;
    if (mem_exccode != EXC_NONE)         exc_code = mem_exccode;
    else if (misaligned)                 exc_code = op_load ? EXC_ADEL : EXC_ADES;
    else if (state == ST_DONE && bus_err) exc_code = EXC_DBE;
  end

`ifdef DM_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // the 255th WAIT cycle without ack ends the transaction
  assign timeout = (state == ST_WAIT) && !dm_ack && (tmo_cnt == 8'd254);

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst_n) begin
    if (cpu_rst_n) begin
      tmo_cnt <= 8'd0;
      bus_err <= 1'b0;
    end else begin
      tmo_cnt <= (state == ST_WAIT && !dm_ack) ? tmo_cnt + 8'd1 : 8'd0;
      if (timeout && !drop_txn)                bus_err <= 1'b1;
      else if (state == ST_DONE && done_exit)  bus_err <= 1'b0;
    end
  end
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst_n) begin
    if (cpu_rst_n) begin
      state      <= ST_IDLE;
      flush_seen <= 1'b0;
      load_buf   <= 32'd0;
      txn_q      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          flush_seen <= 1'b0;
          if (launch) begin
            state <= ST_WAIT;
            txn_q <= txn_now;
          end
        end
        ST_WAIT: begin
          if (flush) flush_seen <= 1'b1;
          if (dm_ack || timeout) begin
            flush_seen <= 1'b0;
            if (drop_txn) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_DONE;
              if (dm_ack) load_buf <= dm_rdata;
            end
          end
        end
        ST_DONE: if (done_exit) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // MEM/WB register; a stalled MEM stage feeds bubbles downstream
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst_n) begin
    if (cpu_rst_n) begin
      wb_wa       <= 5'd0;
      wb_wreg     <= 1'b0;
      wb_whilo    <= 1'b0;
      wb_wd       <= 32'd0;
      wb_hilo     <= 64'd0;
      wb_pc       <= PC_INIT;
      wb_in_delay <= 1'b0;
      wb_exccode  <= EXC_NONE;
    end else if (flush || stall[STALL_BUS-1] == STOP) begin
      wb_wa       <= 5'd0;
      wb_wreg     <= 1'b0;
      wb_whilo    <= 1'b0;
      wb_wd       <= 32'd0;
      wb_hilo     <= 64'd0;
      wb_in_delay <= 1'b0;
      wb_exccode  <= EXC_NONE;
    end else begin
      wb_wa       <= mem_wa;
      wb_wreg     <= mem_wreg && (exc_code == EXC_NONE);
      wb_whilo    <= mem_whilo && (exc_code == EXC_NONE);
      wb_wd       <= mem_mreg ? load_data : mem_wd;
      wb_hilo     <= mem_hilo;
      wb_pc       <= mem_pc;
      wb_in_delay <= mem_in_delay;
      wb_exccode  <= exc_code;
    end
  end

endmodule
